// File: rtl/bus_initiator_pkg.sv
// Shared constants for the cs_/as_/rdy_ peripheral bus initiator: default widths,
// state encodings and bus signal levels.
package bus_initiator_pkg;

    localparam int unsigned BUS_INIT_ADDR_W   = 2;
    localparam int unsigned BUS_INIT_DATA_W   = 32;
    localparam int unsigned BUS_INIT_TIMEOUT  = 16;
    localparam int unsigned BUS_INIT_TO_CNT_W = 5;

    localparam int unsigned BUS_INIT_STATE_W = 1;
    localparam logic [BUS_INIT_STATE_W-1:0] BUS_INIT_ST_IDLE   = 1'b0;
    localparam logic [BUS_INIT_STATE_W-1:0] BUS_INIT_ST_ACCESS = 1'b1;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_initiator.sv
// Single-outstanding master for the cs_/as_/rdy_ peripheral bus (GPIO, UART, timer).
// Define BUS_INIT_TIMEOUT_EN to abort accesses whose responder never asserts rdy_.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int unsigned ADDR_W   = BUS_INIT_ADDR_W,
    parameter int unsigned DATA_W   = BUS_INIT_DATA_W,
    parameter int unsigned TIMEOUT  = BUS_INIT_TIMEOUT,
    parameter int unsigned TO_CNT_W = BUS_INIT_TO_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wr_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rd_data,
    output logic              rsp_err,
    output logic              cs_,
    output logic              as_,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rdy_
);

    if (TIMEOUT < 2 || TIMEOUT > (2 ** TO_CNT_W) - 1) begin : g_bad_cfg
        $error("bus_initiator: TIMEOUT must be >= 2 and fit in TO_CNT_W bits");
    end

    logic [BUS_INIT_STATE_W-1:0] r_state;
    logic [BUS_INIT_STATE_W-1:0] w_nxt_state;
    logic                        r_req_ready;
    logic                        r_rsp_valid;
    logic                        w_nxt_rsp_valid;
    logic [DATA_W-1:0]           r_rsp_rd_data;
    logic [DATA_W-1:0]           w_nxt_rsp_rd_data;
    logic                        r_cs;
    logic                        w_nxt_cs;
    logic                        r_as;
    logic                        w_nxt_as;
    logic                        r_rw;
    logic                        w_nxt_rw;
    logic [ADDR_W-1:0]           r_addr;
    logic [ADDR_W-1:0]           w_nxt_addr;
    logic [DATA_W-1:0]           r_wr_data;
    logic [DATA_W-1:0]           w_nxt_wr_data;
`ifdef BUS_INIT_TIMEOUT_EN
    logic                        r_rsp_err;
    logic                        w_nxt_rsp_err;
    logic [TO_CNT_W-1:0]         r_cnt;
    logic [TO_CNT_W-1:0]         w_nxt_cnt;
`endif

    // Next-state and next-output decode; rdy_ and rd_data only matter in ACCESS.
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_rsp_valid   = 1'b0;
        w_nxt_rsp_rd_data = r_rsp_rd_data;
        w_nxt_cs          = r_cs;
        w_nxt_as          = r_as;
        w_nxt_rw          = r_rw;
        w_nxt_addr        = r_addr;
        w_nxt_wr_data     = r_wr_data;
`ifdef BUS_INIT_TIMEOUT_EN
        w_nxt_rsp_err     = r_rsp_err;
        w_nxt_cnt         = r_cnt;
`endif
        case (r_state)
            BUS_INIT_ST_IDLE: begin
                if (req_valid) begin
                    w_nxt_state   = BUS_INIT_ST_ACCESS;
                    w_nxt_cs      = ENABLE_;
                    w_nxt_as      = ENABLE_;
                    w_nxt_rw      = req_rw;
                    w_nxt_addr    = req_addr;
                    w_nxt_wr_data = req_wr_data;
`ifdef BUS_INIT_TIMEOUT_EN
                    w_nxt_cnt     = '0;
`endif
                end
            end
            BUS_INIT_ST_ACCESS: begin
                if (rdy_ == ENABLE_) begin
                    w_nxt_state       = BUS_INIT_ST_IDLE;
                    w_nxt_rsp_valid   = 1'b1;
                    w_nxt_rsp_rd_data = (r_rw == READ) ? rd_data : '0;
                    w_nxt_cs          = DISABLE_;
                    w_nxt_as          = DISABLE_;
`ifdef BUS_INIT_TIMEOUT_EN
                    w_nxt_rsp_err     = 1'b0;
                end else if (r_cnt == TO_CNT_W'(TIMEOUT - 1)) begin
                    // This idle cycle is the TIMEOUT-th: abort with an error response.
                    w_nxt_state       = BUS_INIT_ST_IDLE;
                    w_nxt_rsp_valid   = 1'b1;
                    w_nxt_rsp_rd_data = '0;
                    w_nxt_rsp_err     = 1'b1;
                    w_nxt_cs          = DISABLE_;
                    w_nxt_as          = DISABLE_;
                    w_nxt_cnt         = r_cnt + TO_CNT_W'(1);
                end else begin
                    w_nxt_cnt         = r_cnt + TO_CNT_W'(1);
`endif
                end
            end
            default: begin
                w_nxt_state = BUS_INIT_ST_IDLE;
                w_nxt_cs    = DISABLE_;
                w_nxt_as    = DISABLE_;
            end
        endcase
    end

    // Async reset releases the bus immediately, even mid-access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= BUS_INIT_ST_IDLE;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rd_data <= '0;
            r_cs          <= DISABLE_;
            r_as          <= DISABLE_;
            r_rw          <= READ;
            r_addr        <= '0;
            r_wr_data     <= '0;
`ifdef BUS_INIT_TIMEOUT_EN
            r_rsp_err     <= 1'b0;
            r_cnt         <= '0;
`endif
        end else begin
            r_state       <= w_nxt_state;
            r_req_ready   <= (w_nxt_state == BUS_INIT_ST_IDLE);
            r_rsp_valid   <= w_nxt_rsp_valid;
            r_rsp_rd_data <= w_nxt_rsp_rd_data;
            r_cs          <= w_nxt_cs;
            r_as          <= w_nxt_as;
            r_rw          <= w_nxt_rw;
            r_addr        <= w_nxt_addr;
            r_wr_data     <= w_nxt_wr_data;
`ifdef BUS_INIT_TIMEOUT_EN
            r_rsp_err     <= w_nxt_rsp_err;
            r_cnt         <= w_nxt_cnt;
`endif
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rd_data = r_rsp_rd_data;
    assign cs_         = r_cs;
    assign as_         = r_as;
    assign rw          = r_rw;
    assign addr        = r_addr;
    assign wr_data     = r_wr_data;
`ifdef BUS_INIT_TIMEOUT_EN
    assign rsp_err     = r_rsp_err;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator with a behavioural GPIO-like responder
// (register 0 reads gpio_in and ignores writes, registers 1-3 are plain storage).
module tb_bus_initiator;
    import bus_initiator_pkg::*;

    localparam int unsigned AW  = BUS_INIT_ADDR_W;
    localparam int unsigned DW  = BUS_INIT_DATA_W;
    localparam int unsigned TMO = BUS_INIT_TIMEOUT;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_rw;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wr_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rd_data;
    logic          rsp_err;
    logic          cs_;
    logic          as_;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rdy_;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_initiator dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .rsp_valid   (rsp_valid),
        .rsp_rd_data (rsp_rd_data),
        .rsp_err     (rsp_err),
        .cs_         (cs_),
        .as_         (as_),
        .rw          (rw),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .rdy_        (rdy_)
    );

    // Behavioural responder: rdy_ low after r_waits cycles of cs_ low, and stays low
    // one cycle after cs_ rises (the trailing rdy_ the initiator must ignore).
    int unsigned   r_waits = 0;
    logic          stuck = 1'b0;
    int unsigned   wcnt;
    logic [DW-1:0] gpio_in = 32'h0000_003C;
    logic [DW-1:0] resp_mem [4];

    always @(posedge clk) begin
        if (reset) begin
            rdy_    <= 1'b1;
            wcnt    <= 0;
            rd_data <= '0;
            for (int i = 0; i < 4; i++) resp_mem[i] <= '0;
        end else if (cs_ == 1'b0 && !stuck) begin
            if (wcnt >= r_waits) begin
                rdy_ <= 1'b0;
                if (rw) begin
                    rd_data <= (addr == 0) ? gpio_in : resp_mem[addr];
                end else begin
                    rd_data <= $urandom;
                    if (addr != 0) resp_mem[addr] <= wr_data;
                end
            end else begin
                rdy_    <= 1'b1;
                wcnt    <= wcnt + 1;
                rd_data <= $urandom;
            end
        end else begin
            rdy_    <= 1'b1;
            wcnt    <= 0;
            rd_data <= $urandom;
        end
    end

    // Reference model: what the register space should hold, from the bus rules alone.
    logic [DW-1:0] ref_mem [4];

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return (a == 0) ? gpio_in : ref_mem[a];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    endtask

    // One access from an idle bus: checks latency, bus stability, response and release.
    task automatic run_access(input logic i_rw, input logic [AW-1:0] i_addr,
                              input logic [DW-1:0] i_wd, input int unsigned i_waits,
                              input logic i_stuck, input int exp_lat,
                              input logic [DW-1:0] exp_rd, input logic exp_err,
                              input string tag);
        int   lat;
        logic bad;
        lat = 0;
        bad = 1'b0;
        @(negedge clk);
        check({tag, " req_ready idle"}, 64'(req_ready), 64'(1));
        r_waits     = i_waits;
        stuck       = i_stuck;
        req_valid   = 1'b1;
        req_rw      = i_rw;
        req_addr    = i_addr;
        req_wr_data = i_wd;
        @(negedge clk);
        req_valid   = 1'b0;
        req_rw      = 1'($urandom);
        req_addr    = AW'($urandom);
        req_wr_data = $urandom;
        for (int c = 1; c <= 200; c++) begin
            if (rsp_valid) begin
                lat = c;
                break;
            end
            if (cs_ !== 1'b0 || as_ !== 1'b0 || rw !== i_rw || addr !== i_addr ||
                wr_data !== i_wd || req_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check({tag, " bus stable"}, 64'(bad), 64'(0));
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " rd_data"}, 64'(rsp_rd_data), 64'(exp_rd));
        check({tag, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
        check({tag, " cs_/as_ released"}, {62'd0, cs_, as_}, 64'(3));
        @(negedge clk);
        check({tag, " single pulse"}, {62'd0, rsp_valid, cs_}, 64'(1));
        stuck = 1'b0;
    endtask

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        int unsigned   waits;
        logic [DW-1:0] exp_rd;
        int            exp_lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{WRITE, 2'd1, 32'h0000_00A5, 0, 32'h0,         3};
        vecs[1] = '{READ,  2'd0, 32'h0,         0, 32'h0000_003C, 3};
        vecs[2] = '{WRITE, 2'd2, 32'hDEAD_BEEF, 5, 32'h0,         8};
        vecs[3] = '{READ,  2'd2, 32'h0,         5, 32'hDEAD_BEEF, 8};
        vecs[4] = '{READ,  2'd1, 32'h0,         1, 32'h0000_00A5, 4};
        vecs[5] = '{WRITE, 2'd3, 32'h1234_5678, 2, 32'h0,         5};
        vecs[6] = '{READ,  2'd3, 32'h0,         0, 32'h1234_5678, 3};
        vecs[7] = '{WRITE, 2'd0, 32'hFFFF_FFFF, 0, 32'h0,         3};
        vecs[8] = '{READ,  2'd0, 32'h0,         3, 32'h0000_003C, 6};

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_rw      = 1'b0;
        req_addr    = '0;
        req_wr_data = '0;
        clear_ref();
        repeat (3) @(posedge clk);
        #1;
        check("reset cs_/as_/rw", {61'd0, cs_, as_, rw}, 64'(7));
        check("reset addr/wr_data", {30'd0, addr, wr_data}, 64'(0));
        check("reset rsp", {31'd0, rsp_valid, rsp_err, rsp_rd_data}, 64'(0));
        check("reset req_ready", 64'(req_ready), 64'(1));
        @(negedge clk);
        reset = 1'b0;

        // Directed table, including the GPIO write/read and the 5-wait-state access.
        for (int i = 0; i < 9; i++) begin
            run_access(vecs[i].rw, vecs[i].addr, vecs[i].wd, vecs[i].waits, 1'b0,
                       vecs[i].exp_lat, vecs[i].exp_rd, 1'b0, $sformatf("vec%0d", i));
            if (vecs[i].rw == WRITE && vecs[i].addr != 0) ref_mem[vecs[i].addr] = vecs[i].wd;
            if (i == 0) check("gpio_out after write", 64'(resp_mem[1]), 64'h0000_00A5);
        end

        // Randomized accesses against the reference model.
        for (int n = 0; n < 30; n++) begin
            logic          t_rw;
            logic [AW-1:0] t_a;
            logic [DW-1:0] t_d;
            int unsigned   t_w;
            t_rw = 1'($urandom);
            t_a  = AW'($urandom);
            t_d  = $urandom;
            t_w  = $urandom_range(0, 6);
            if (n % 7 == 0) gpio_in = $urandom;
            run_access(t_rw, t_a, t_d, t_w, 1'b0, 3 + int'(t_w),
                       t_rw ? ref_read(t_a) : '0, 1'b0, $sformatf("rand%0d", n));
            if (t_rw == WRITE && t_a != 0) ref_mem[t_a] = t_d;
        end

`ifdef BUS_INIT_TIMEOUT_EN
        run_access(READ, 2'd1, '0, 0, 1'b1, TMO + 1, '0, 1'b1, "timeout stuck");
        run_access(READ, 2'd1, '0, TMO - 2, 1'b0, TMO + 1, ref_read(2'd1), 1'b0,
                   "rdy_ in last cycle");
        run_access(READ, 2'd1, '0, TMO - 1, 1'b0, TMO + 1, '0, 1'b1, "rdy_ one late");
        run_access(READ, 2'd2, '0, 0, 1'b0, 3, ref_read(2'd2), 1'b0, "after timeout");
`else
        begin
            int rsp_cnt;
            int cs_hi;
            rsp_cnt = 0;
            cs_hi   = 0;
            @(negedge clk);
            stuck     = 1'b1;
            req_valid = 1'b1;
            req_rw    = READ;
            req_addr  = 2'd1;
            @(negedge clk);
            req_valid = 1'b0;
            for (int c = 0; c < 1000; c++) begin
                if (rsp_valid) rsp_cnt++;
                if (cs_ !== 1'b0) cs_hi++;
                @(negedge clk);
            end
            check("no timeout rsp", 64'(rsp_cnt), 64'(0));
            check("no timeout cs_ held", 64'(cs_hi), 64'(0));
            reset = 1'b1;
            stuck = 1'b0;
            clear_ref();
            @(negedge clk);
            reset = 1'b0;
            run_access(READ, 2'd0, '0, 0, 1'b0, 3, gpio_in, 1'b0, "after hang");
        end
`endif

        // Back-to-back reads with req_valid held: three accesses, one idle cs_ cycle between.
        begin
            int pulses;
            pulses = 0;
            @(negedge clk);
            r_waits   = 0;
            req_valid = 1'b1;
            req_rw    = READ;
            req_addr  = 2'd1;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (c == 9) req_valid = 1'b0;
                if (rsp_valid) pulses++;
                check($sformatf("b2b cs_ c%0d", c), 64'(cs_),
                      64'((c <= 8 && c % 3 != 0) ? 0 : 1));
                check($sformatf("b2b rsp c%0d", c), 64'(rsp_valid),
                      64'((c == 3 || c == 6 || c == 9) ? 1 : 0));
                if (rsp_valid) check($sformatf("b2b data c%0d", c), 64'(rsp_rd_data),
                                     64'(ref_read(2'd1)));
            end
            check("b2b pulse count", 64'(pulses), 64'(3));
        end

        // Reset in the second ACCESS cycle: bus released at once, no response.
        begin
            int rsp_cnt;
            rsp_cnt = 0;
            run_access(WRITE, 2'd3, 32'hCAFE_F00D, 0, 1'b0, 3, '0, 1'b0, "pre-reset write");
            @(negedge clk);
            r_waits   = 3;
            req_valid = 1'b1;
            req_rw    = READ;
            req_addr  = 2'd3;
            @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            check("midreset in access", 64'(cs_), 64'(0));
            reset = 1'b1;
            #1;
            check("midreset release", {62'd0, cs_, as_}, 64'(3));
            check("midreset no rsp", 64'(rsp_valid), 64'(0));
            clear_ref();
            @(negedge clk);
            reset = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (rsp_valid) rsp_cnt++;
                @(negedge clk);
            end
            check("midreset silent", 64'(rsp_cnt), 64'(0));
            run_access(WRITE, 2'd2, 32'h0BAD_F00D, 0, 1'b0, 3, '0, 1'b0, "post-reset write");
            ref_mem[2] = 32'h0BAD_F00D;
            run_access(READ, 2'd2, '0, 2, 1'b0, 5, ref_read(2'd2), 1'b0, "post-reset read");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
